// File: rtl/cvxif_dispatch_ctrl.sv
// CV-X-IF dispatch controller: routes offloaded instructions to one of several
// coprocessors, tracks them by id until they retire, and arbitrates the results.
module cvxif_dispatch_ctrl #(
   parameter int NrCoproc       = 2,
   parameter int IdWidth        = 3,
   parameter int DataWidth      = 64,
   parameter int MaxOutstanding = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                issue_valid_i,
   output logic                                issue_ready_o,
   input  logic [31:0]                         issue_instr_i,
   input  logic [IdWidth-1:0]                  issue_id_i,
   output logic                                issue_accept_o,
   output logic                                issue_writeback_o,
   input  logic                                commit_valid_i,
   input  logic [IdWidth-1:0]                  commit_id_i,
   input  logic                                commit_kill_i,
   output logic                                result_valid_o,
   input  logic                                result_ready_i,
   output logic [IdWidth-1:0]                  result_id_o,
   output logic [DataWidth-1:0]                result_data_o,
   output logic [4:0]                          result_rd_o,
   output logic                                result_we_o,
   output logic [NrCoproc-1:0]                 cp_issue_valid_o,
   input  logic [NrCoproc-1:0]                 cp_issue_ready_i,
   input  logic [NrCoproc-1:0]                 cp_issue_accept_i,
   input  logic [NrCoproc-1:0]                 cp_issue_writeback_i,
   output logic [NrCoproc-1:0]                 cp_commit_valid_o,
   output logic                                cp_commit_kill_o,
   output logic [IdWidth-1:0]                  cp_commit_id_o,
   input  logic [NrCoproc-1:0]                 cp_result_valid_i,
   output logic [NrCoproc-1:0]                 cp_result_ready_o,
   input  logic [NrCoproc-1:0][IdWidth-1:0]    cp_result_id_i,
   input  logic [NrCoproc-1:0][DataWidth-1:0]  cp_result_data_i,
   input  logic [NrCoproc-1:0][4:0]            cp_result_rd_i,
   input  logic [NrCoproc-1:0]                 cp_result_we_i,
   output logic                                err_unknown_id_o
);

   localparam int NrEntries = 1 << IdWidth;
   localparam int PtrW      = $clog2(NrCoproc);
   localparam int CntW      = IdWidth + 1;
   localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

   // tracker state
   logic [NrEntries-1:0]           entry_valid_q, entry_valid_d;
   logic [NrEntries-1:0]           committed_q, committed_d;
   logic [NrEntries-1:0][PtrW-1:0] owner_q, owner_d;
   logic [CntW-1:0]                count_q, count_d;

   // result output register and arbiter pointer
   logic                 out_valid_q, out_valid_d;
   logic [IdWidth-1:0]   out_id_q, out_id_d;
   logic [DataWidth-1:0] out_data_q, out_data_d;
   logic [4:0]           out_rd_q, out_rd_d;
   logic                 out_we_q, out_we_d;
   logic [PtrW-1:0]      rr_q, rr_d;
   logic                 err_q, err_d;

   logic [1:0]      tgt_raw;
   logic            opcode_hit;
   logic            routable;
   logic [PtrW-1:0] tgt;
   logic            slot_free;
   logic            issue_go;
   logic            tgt_ready;
   logic            issue_acc;

   logic            commit_hit;
   logic            kill_fire;
   logic            commit_fire;

   logic [PtrW-1:0] cand;
   logic            res_found;
   logic [PtrW-1:0] res_win;
   logic            drain;
   logic            grant;
   logic [IdWidth-1:0] res_id;
   logic            res_known;

   logic unused_instr_bits;
   assign unused_instr_bits = ^issue_instr_i[31:7];

   // Opcode decode; a target beyond the attached coprocessors is unroutable.
   always_comb begin
      tgt_raw    = 2'd0;
      opcode_hit = 1'b0;
      case (issue_instr_i[6:0])
         7'b0001011: begin tgt_raw = 2'd0; opcode_hit = 1'b1; end
         7'b0101011: begin tgt_raw = 2'd1; opcode_hit = 1'b1; end
         7'b1011011: begin tgt_raw = 2'd2; opcode_hit = 1'b1; end
         7'b1111011: begin tgt_raw = 2'd3; opcode_hit = 1'b1; end
         default:    begin tgt_raw = 2'd0; opcode_hit = 1'b0; end
      endcase
      routable = opcode_hit && (int'(tgt_raw) < NrCoproc);
      tgt      = PtrW'(tgt_raw);
   end

   // A busy id also covers the same-id issue-and-free case: it stalls a cycle.
   always_comb begin
      cp_issue_valid_o  = '0;
      slot_free         = (count_q < MaxCnt) && !entry_valid_q[issue_id_i];
      issue_go          = issue_valid_i && routable && slot_free;
      tgt_ready         = routable ? cp_issue_ready_i[tgt] : 1'b0;
      issue_acc         = 1'b0;
      issue_accept_o    = 1'b0;
      issue_writeback_o = 1'b0;
      if (issue_go) begin
         cp_issue_valid_o[tgt] = 1'b1;
      end
      issue_ready_o = issue_valid_i && (!routable || (slot_free && tgt_ready));
      if (issue_go && tgt_ready) begin
         issue_acc         = cp_issue_accept_i[tgt];
         issue_accept_o    = cp_issue_accept_i[tgt];
         issue_writeback_o = cp_issue_accept_i[tgt] && cp_issue_writeback_i[tgt];
      end
   end

   always_comb begin
      cp_commit_valid_o = '0;
      commit_hit        = commit_valid_i && entry_valid_q[commit_id_i];
      if (commit_hit) begin
         cp_commit_valid_o[owner_q[commit_id_i]] = 1'b1;
      end
      cp_commit_kill_o = commit_valid_i && commit_kill_i;
      cp_commit_id_o   = commit_id_i;
   end

   // Round-robin search starting at the pointer.
   always_comb begin
      cand      = '0;
      res_found = 1'b0;
      res_win   = '0;
      for (int k = 0; k < NrCoproc; k++) begin
         cand = PtrW'((int'(rr_q) + k) % NrCoproc);
         if (!res_found && cp_result_valid_i[cand]) begin
            res_found = 1'b1;
            res_win   = cand;
         end
      end
   end

   // Grant only when the output register is empty or emptying this cycle.
   always_comb begin
      drain             = out_valid_q && result_ready_i;
      grant             = res_found && (!out_valid_q || drain);
      res_id            = cp_result_id_i[res_win];
      res_known         = entry_valid_q[res_id] && committed_q[res_id];
      cp_result_ready_o = '0;
      if (grant) begin
         cp_result_ready_o[res_win] = 1'b1;
      end

      out_valid_d = out_valid_q && !drain;
      out_id_d    = out_id_q;
      out_data_d  = out_data_q;
      out_rd_d    = out_rd_q;
      out_we_d    = out_we_q;
      rr_d        = rr_q;
      err_d       = err_q;
      if (grant) begin
         rr_d = PtrW'((int'(res_win) + 1) % NrCoproc);
         if (res_known) begin
            out_valid_d = 1'b1;
            out_id_d    = res_id;
            out_data_d  = cp_result_data_i[res_win];
            out_rd_d    = cp_result_rd_i[res_win];
            out_we_d    = cp_result_we_i[res_win];
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // Tracker update; accept never targets an entry being freed, since it must be idle.
   always_comb begin
      entry_valid_d = entry_valid_q;
      committed_d   = committed_q;
      owner_d       = owner_q;
      kill_fire     = commit_hit && commit_kill_i && !(drain && (out_id_q == commit_id_i));
      commit_fire   = commit_hit && !commit_kill_i;

      if (commit_fire) begin
         committed_d[commit_id_i] = 1'b1;
      end
      if (kill_fire) begin
         entry_valid_d[commit_id_i] = 1'b0;
         committed_d[commit_id_i]   = 1'b0;
      end
      if (drain) begin
         entry_valid_d[out_id_q] = 1'b0;
         committed_d[out_id_q]   = 1'b0;
      end
      if (issue_acc) begin
         entry_valid_d[issue_id_i] = 1'b1;
         committed_d[issue_id_i]   = 1'b0;
         owner_d[issue_id_i]       = tgt;
      end
      count_d = count_q + CntW'(issue_acc) - CntW'(kill_fire) - CntW'(drain);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         entry_valid_q <= '0;
         committed_q   <= '0;
         owner_q       <= '0;
         count_q       <= '0;
         out_valid_q   <= 1'b0;
         out_id_q      <= '0;
         out_data_q    <= '0;
         out_rd_q      <= '0;
         out_we_q      <= 1'b0;
         rr_q          <= '0;
         err_q         <= 1'b0;
      end else begin
         entry_valid_q <= entry_valid_d;
         committed_q   <= committed_d;
         owner_q       <= owner_d;
         count_q       <= count_d;
         out_valid_q   <= out_valid_d;
         out_id_q      <= out_id_d;
         out_data_q    <= out_data_d;
         out_rd_q      <= out_rd_d;
         out_we_q      <= out_we_d;
         rr_q          <= rr_d;
         err_q         <= err_d;
      end
   end

   assign result_valid_o   = out_valid_q;
   assign result_id_o      = out_id_q;
   assign result_data_o    = out_data_q;
   assign result_rd_o      = out_rd_q;
   assign result_we_o      = out_we_q;
   assign err_unknown_id_o = err_q;

endmodule

// File: tb/tb_cvxif_dispatch_ctrl.sv
// Directed bench for cvxif_dispatch_ctrl with default parameters
// (2 coprocessors, 3-bit ids, 64-bit data, 4 outstanding).
module tb_cvxif_dispatch_ctrl;

   localparam logic [6:0] OpCp0 = 7'b0001011;
   localparam logic [6:0] OpCp1 = 7'b0101011;
   localparam logic [6:0] OpCp2 = 7'b1011011;
   localparam logic [6:0] OpAlu = 7'b0110011;

   logic        clk;
   logic        rst_n;
   logic        issue_valid;
   logic        issue_ready;
   logic [31:0] issue_instr;
   logic [2:0]  issue_id;
   logic        issue_accept;
   logic        issue_writeback;
   logic        commit_valid;
   logic [2:0]  commit_id;
   logic        commit_kill;
   logic        result_valid;
   logic        result_ready;
   logic [2:0]  result_id;
   logic [63:0] result_data;
   logic [4:0]  result_rd;
   logic        result_we;
   logic [1:0]  cp_issue_valid;
   logic [1:0]  cp_issue_ready;
   logic [1:0]  cp_issue_accept;
   logic [1:0]  cp_issue_writeback;
   logic [1:0]  cp_commit_valid;
   logic        cp_commit_kill;
   logic [2:0]  cp_commit_id;
   logic [1:0]  cp_result_valid;
   logic [1:0]  cp_result_ready;
   logic [1:0][2:0]  cp_result_id;
   logic [1:0][63:0] cp_result_data;
   logic [1:0][4:0]  cp_result_rd;
   logic [1:0]       cp_result_we;
   logic        err_unknown_id;

   int compare_count = 0;
   int fail_count    = 0;

   cvxif_dispatch_ctrl #(
      .NrCoproc(2), .IdWidth(3), .DataWidth(64), .MaxOutstanding(4)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
      .issue_instr_i(issue_instr), .issue_id_i(issue_id),
      .issue_accept_o(issue_accept), .issue_writeback_o(issue_writeback),
      .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
      .result_valid_o(result_valid), .result_ready_i(result_ready),
      .result_id_o(result_id), .result_data_o(result_data),
      .result_rd_o(result_rd), .result_we_o(result_we),
      .cp_issue_valid_o(cp_issue_valid), .cp_issue_ready_i(cp_issue_ready),
      .cp_issue_accept_i(cp_issue_accept), .cp_issue_writeback_i(cp_issue_writeback),
      .cp_commit_valid_o(cp_commit_valid), .cp_commit_kill_o(cp_commit_kill),
      .cp_commit_id_o(cp_commit_id),
      .cp_result_valid_i(cp_result_valid), .cp_result_ready_o(cp_result_ready),
      .cp_result_id_i(cp_result_id), .cp_result_data_i(cp_result_data),
      .cp_result_rd_i(cp_result_rd), .cp_result_we_i(cp_result_we),
      .err_unknown_id_o(err_unknown_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      compare_count++;
      assert (observed === expected) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [6:0] opcode,
                                input logic [2:0] id, input logic [1:0] rdy,
                                input logic [1:0] acc, input logic [1:0] wb);
      issue_valid        = valid;
      issue_instr        = {25'h1a5a5a5, opcode};
      issue_id           = id;
      cp_issue_ready     = rdy;
      cp_issue_accept    = acc;
      cp_issue_writeback = wb;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setCommit(input logic valid, input logic [2:0] id, input logic kill);
      commit_valid = valid;
      commit_id    = id;
      commit_kill  = kill;
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 7'd0, 3'd0, 2'b00, 2'b00, 2'b00);
      setCommit(1'b0, 3'd0, 1'b0);
      result_ready    = 1'b0;
      cp_result_valid = '0;
      cp_result_id    = '0;
      cp_result_data  = '0;
      cp_result_rd    = '0;
      cp_result_we    = '0;

      // reset state
      repeat (2) @(posedge clk);
      #3;
      checkOutput("rst_result_valid", 64'(result_valid), 64'd0);
      checkOutput("rst_result_data", result_data, 64'd0);
      checkOutput("rst_err", 64'(err_unknown_id), 64'd0);
      checkOutput("rst_issue_ready", 64'(issue_ready), 64'd0);
      checkOutput("rst_cp_issue_valid", 64'(cp_issue_valid), 64'd0);
      checkOutput("rst_cp_result_ready", 64'(cp_result_ready), 64'd0);
      rst_n = 1'b1;
      tick();

      // routable issue to cp1
      applyStimulus(1'b1, OpCp1, 3'd2, 2'b10, 2'b10, 2'b10);
      #1;
      checkOutput("iss_cp1_valid", 64'(cp_issue_valid), 64'b10);
      checkOutput("iss_cp1_ready", 64'(issue_ready), 64'd1);
      checkOutput("iss_cp1_accept", 64'(issue_accept), 64'd1);
      checkOutput("iss_cp1_wb", 64'(issue_writeback), 64'd1);
      tick();
      checkOutput("iss_cp1_count", 64'(dut.count_q), 64'd1);

      // unroutable opcodes complete immediately without acceptance
      applyStimulus(1'b1, OpAlu, 3'd5, 2'b11, 2'b11, 2'b00);
      #1;
      checkOutput("unr_alu_ready", 64'(issue_ready), 64'd1);
      checkOutput("unr_alu_accept", 64'(issue_accept), 64'd0);
      checkOutput("unr_alu_cpvalid", 64'(cp_issue_valid), 64'd0);
      tick();
      checkOutput("unr_alu_count", 64'(dut.count_q), 64'd1);
      applyStimulus(1'b1, OpCp2, 3'd5, 2'b11, 2'b11, 2'b00);
      #1;
      checkOutput("unr_cp2_ready", 64'(issue_ready), 64'd1);
      checkOutput("unr_cp2_cpvalid", 64'(cp_issue_valid), 64'd0);
      checkOutput("unr_cp2_accept", 64'(issue_accept), 64'd0);
      tick();

      // fill the table: ids 0,1 to cp0, busy id 2 stalls, id 3 to cp0
      applyStimulus(1'b1, OpCp0, 3'd0, 2'b01, 2'b01, 2'b00);
      #1;
      checkOutput("fill0_accept", 64'(issue_accept), 64'd1);
      checkOutput("fill0_wb", 64'(issue_writeback), 64'd0);
      tick();
      applyStimulus(1'b1, OpCp0, 3'd1, 2'b01, 2'b01, 2'b00);
      tick();
      applyStimulus(1'b1, OpCp1, 3'd2, 2'b10, 2'b10, 2'b10);
      #1;
      checkOutput("busy_id_ready", 64'(issue_ready), 64'd0);
      checkOutput("busy_id_cpvalid", 64'(cp_issue_valid), 64'd0);
      tick();
      applyStimulus(1'b1, OpCp0, 3'd3, 2'b01, 2'b01, 2'b00);
      tick();
      checkOutput("full_count", 64'(dut.count_q), 64'd4);

      // fifth issue stalls while full
      applyStimulus(1'b1, OpCp1, 3'd4, 2'b10, 2'b10, 2'b00);
      #1;
      checkOutput("full_ready", 64'(issue_ready), 64'd0);
      checkOutput("full_cpvalid", 64'(cp_issue_valid), 64'd0);
      tick();
      setCommit(1'b1, 3'd2, 1'b0);
      #1;
      checkOutput("cmt2_cpvalid", 64'(cp_commit_valid), 64'b10);
      checkOutput("cmt2_kill", 64'(cp_commit_kill), 64'd0);
      checkOutput("cmt2_id", 64'(cp_commit_id), 64'd2);
      checkOutput("cmt2_issue_ready", 64'(issue_ready), 64'd0);
      tick();
      setCommit(1'b0, 3'd0, 1'b0);
      result_ready       = 1'b1;
      cp_result_valid    = 2'b10;
      cp_result_id[1]    = 3'd2;
      cp_result_data[1]  = 64'hAAAA;
      cp_result_rd[1]    = 5'd7;
      cp_result_we[1]    = 1'b1;
      #1;
      checkOutput("res2_cpready", 64'(cp_result_ready), 64'b10);
      checkOutput("res2_issue_ready", 64'(issue_ready), 64'd0);
      tick();
      cp_result_valid = 2'b00;
      #1;
      checkOutput("res2_valid", 64'(result_valid), 64'd1);
      checkOutput("res2_id", 64'(result_id), 64'd2);
      checkOutput("res2_data", result_data, 64'hAAAA);
      checkOutput("res2_rd", 64'(result_rd), 64'd7);
      checkOutput("res2_we", 64'(result_we), 64'd1);
      checkOutput("res2_still_full", 64'(issue_ready), 64'd0);
      tick();
      #1;
      checkOutput("fifth_ready", 64'(issue_ready), 64'd1);
      checkOutput("fifth_accept", 64'(issue_accept), 64'd1);
      checkOutput("fifth_cpvalid", 64'(cp_issue_valid), 64'b10);
      tick();
      applyStimulus(1'b0, 7'd0, 3'd0, 2'b00, 2'b00, 2'b00);
      checkOutput("fifth_count", 64'(dut.count_q), 64'd4);
      checkOutput("fifth_resvalid", 64'(result_valid), 64'd0);

      // round-robin tie: cp0 first, then cp1 on the next tie
      setCommit(1'b1, 3'd0, 1'b0);
      #1;
      checkOutput("cmt0_cpvalid", 64'(cp_commit_valid), 64'b01);
      tick();
      setCommit(1'b1, 3'd4, 1'b0);
      #1;
      checkOutput("cmt4_cpvalid", 64'(cp_commit_valid), 64'b10);
      tick();
      setCommit(1'b1, 3'd3, 1'b0);
      tick();
      setCommit(1'b0, 3'd0, 1'b0);
      cp_result_valid   = 2'b11;
      cp_result_id[0]   = 3'd0;
      cp_result_data[0] = 64'h100;
      cp_result_rd[0]   = 5'd1;
      cp_result_we[0]   = 1'b1;
      cp_result_id[1]   = 3'd4;
      cp_result_data[1] = 64'h400;
      cp_result_rd[1]   = 5'd4;
      cp_result_we[1]   = 1'b1;
      #1;
      checkOutput("rr_t0_cpready", 64'(cp_result_ready), 64'b01);
      tick();
      cp_result_id[0]   = 3'd3;
      cp_result_data[0] = 64'h300;
      cp_result_rd[0]   = 5'd3;
      #1;
      checkOutput("rr_t1_valid", 64'(result_valid), 64'd1);
      checkOutput("rr_t1_id", 64'(result_id), 64'd0);
      checkOutput("rr_t1_data", result_data, 64'h100);
      checkOutput("rr_t1_cpready", 64'(cp_result_ready), 64'b10);
      tick();
      cp_result_valid = 2'b01;
      #1;
      checkOutput("rr_t2_id", 64'(result_id), 64'd4);
      checkOutput("rr_t2_data", result_data, 64'h400);
      checkOutput("rr_t2_cpready", 64'(cp_result_ready), 64'b01);
      tick();
      cp_result_valid = 2'b00;
      #1;
      checkOutput("rr_t3_id", 64'(result_id), 64'd3);
      checkOutput("rr_t3_data", result_data, 64'h300);
      checkOutput("rr_t3_rd", 64'(result_rd), 64'd3);
      tick();
      checkOutput("rr_done_valid", 64'(result_valid), 64'd0);
      checkOutput("rr_done_count", 64'(dut.count_q), 64'd1);

      // backpressure holds the output register and blocks further grants
      applyStimulus(1'b1, OpCp1, 3'd5, 2'b10, 2'b10, 2'b10);
      tick();
      applyStimulus(1'b1, OpCp0, 3'd6, 2'b01, 2'b01, 2'b01);
      tick();
      applyStimulus(1'b0, 7'd0, 3'd0, 2'b00, 2'b00, 2'b00);
      setCommit(1'b1, 3'd5, 1'b0);
      tick();
      setCommit(1'b1, 3'd6, 1'b0);
      tick();
      setCommit(1'b0, 3'd0, 1'b0);
      checkOutput("bp_count", 64'(dut.count_q), 64'd3);
      result_ready      = 1'b0;
      cp_result_valid   = 2'b11;
      cp_result_id[0]   = 3'd6;
      cp_result_data[0] = 64'h666;
      cp_result_rd[0]   = 5'd6;
      cp_result_we[0]   = 1'b0;
      cp_result_id[1]   = 3'd5;
      cp_result_data[1] = 64'h555;
      cp_result_rd[1]   = 5'd5;
      cp_result_we[1]   = 1'b1;
      #1;
      checkOutput("bp_grant_cp1", 64'(cp_result_ready), 64'b10);
      tick();
      cp_result_valid = 2'b01;
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput("bp_hold_valid", 64'(result_valid), 64'd1);
         checkOutput("bp_hold_id", 64'(result_id), 64'd5);
         checkOutput("bp_hold_data", result_data, 64'h555);
         checkOutput("bp_hold_rd", 64'(result_rd), 64'd5);
         checkOutput("bp_hold_cpready", 64'(cp_result_ready), 64'd0);
         tick();
      end
      result_ready = 1'b1;
      #1;
      checkOutput("bp_release_cpready", 64'(cp_result_ready), 64'b01);
      checkOutput("bp_release_id", 64'(result_id), 64'd5);
      tick();
      cp_result_valid = 2'b00;
      #1;
      checkOutput("bp_next_id", 64'(result_id), 64'd6);
      checkOutput("bp_next_data", result_data, 64'h666);
      checkOutput("bp_next_we", 64'(result_we), 64'd0);
      tick();
      checkOutput("bp_done_valid", 64'(result_valid), 64'd0);
      checkOutput("bp_done_count", 64'(dut.count_q), 64'd1);

      // kill then a stale result for the killed id
      setCommit(1'b1, 3'd1, 1'b1);
      #1;
      checkOutput("kill1_cpvalid", 64'(cp_commit_valid), 64'b01);
      checkOutput("kill1_kill", 64'(cp_commit_kill), 64'd1);
      tick();
      setCommit(1'b0, 3'd0, 1'b0);
      checkOutput("kill1_count", 64'(dut.count_q), 64'd0);
      cp_result_valid   = 2'b01;
      cp_result_id[0]   = 3'd1;
      cp_result_data[0] = 64'hDEAD;
      #1;
      checkOutput("stale_cpready", 64'(cp_result_ready), 64'b01);
      tick();
      cp_result_valid = 2'b00;
      #1;
      checkOutput("stale_dropped", 64'(result_valid), 64'd0);
      checkOutput("stale_err", 64'(err_unknown_id), 64'd1);
      tick();
      checkOutput("stale_err_sticky", 64'(err_unknown_id), 64'd1);

      // reset in the middle of a held result
      applyStimulus(1'b1, OpCp0, 3'd0, 2'b01, 2'b01, 2'b01);
      tick();
      applyStimulus(1'b0, 7'd0, 3'd0, 2'b00, 2'b00, 2'b00);
      setCommit(1'b1, 3'd0, 1'b0);
      tick();
      setCommit(1'b0, 3'd0, 1'b0);
      result_ready      = 1'b0;
      cp_result_valid   = 2'b01;
      cp_result_id[0]   = 3'd0;
      cp_result_data[0] = 64'h77;
      tick();
      cp_result_valid = 2'b00;
      #1;
      checkOutput("midrst_pre_valid", 64'(result_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_valid", 64'(result_valid), 64'd0);
      checkOutput("midrst_data", result_data, 64'd0);
      checkOutput("midrst_err", 64'(err_unknown_id), 64'd0);
      checkOutput("midrst_count", 64'(dut.count_q), 64'd0);
      tick();
      #2;
      rst_n = 1'b1;
      tick();
      tick();
      checkOutput("postrst_valid", 64'(result_valid), 64'd0);
      checkOutput("postrst_cpready", 64'(cp_result_ready), 64'd0);
      applyStimulus(1'b1, OpCp0, 3'd0, 2'b01, 2'b01, 2'b00);
      #1;
      checkOutput("postrst_issue_ready", 64'(issue_ready), 64'd1);
      checkOutput("postrst_issue_accept", 64'(issue_accept), 64'd1);
      tick();
      applyStimulus(1'b0, 7'd0, 3'd0, 2'b00, 2'b00, 2'b00);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
      $finish;
   end

endmodule
